// File: rtl/ps2_tx_apb_if.sv
// APB slave bus bundle for the PS/2 transmitter register block.
interface ps2_tx_apb_if;
   logic [31:0] paddr;
   logic        psel;
   logic        penable;
   logic [2:0]  pprot;
   logic        pwrite;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic        pready;
   logic [31:0] prdata;
   logic        pslverr;

   modport slave (
      input  paddr, psel, penable, pprot, pwrite, pwdata, pstrb,
      output pready, prdata, pslverr
   );

   modport master (
      output paddr, psel, penable, pprot, pwrite, pwdata, pstrb,
      input  pready, prdata, pslverr
   );
endinterface

// File: rtl/ps2_tx_apb.sv
// PS/2 host-to-device byte transmitter with an APB register front end.
// TXDATA (offset 0) starts a frame; STATUS (offset 4) reports busy/done/ack_err/timeout.
module ps2_tx_apb #(
   parameter int CLK_INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES     = 750000
) (
   input  logic clock,
   input  logic reset,
   ps2_tx_apb_if.slave apb,
   input  logic ps2_clk,
   input  logic ps2_data,
   output logic ps2_clk_oe,
   output logic ps2_data_oe
);
   localparam int IW = $clog2(CLK_INHIBIT_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, INHIBIT, SEND, ACK} state_t;

   state_t        state, state_n;
   logic [IW-1:0] inh_cnt, inh_n;
   logic [TW-1:0] tmo_cnt, tmo_n, tmo_inc;
   logic [3:0]    bit_cnt, bit_n;
   logic [7:0]    tx_byte;
   logic          parity;
   logic          done, ack_err, timeout;
   logic [2:0]    clk_sync;
   logic [1:0]    data_sync;
   logic          clk_oe_n, data_oe_n;
   logic          ack_evt, tmo_evt, tmo_hit;
   logic          clk_fall;
   logic [9:0]    frame;

   logic          access, wr, wr_tx, wr_go, rd_status;
   logic [1:0]    reg_sel;
   logic          unused;

   assign unused    = ^{apb.pprot, apb.paddr[31:4], apb.paddr[1:0], apb.pwdata[31:8], apb.pstrb[3:1]};

   assign reg_sel   = apb.paddr[3:2];
   assign access    = apb.psel & apb.penable;
   assign wr        = access & apb.pwrite;
   assign wr_tx     = wr & (reg_sel == 2'd0);
   assign wr_go     = wr_tx & apb.pstrb[0] & (state == IDLE);
   assign rd_status = access & ~apb.pwrite & (reg_sel == 2'd1);

   assign apb.pready  = access;
   assign apb.pslverr = wr_tx & (state != IDLE);

   // Read mux: decoded from the address alone, zero for unmapped offsets.
   always_comb begin
      apb.prdata = 32'd0;
      case (reg_sel)
         2'd0:    apb.prdata = {24'd0, tx_byte};
         2'd1:    apb.prdata = {28'd0, timeout, ack_err, done, state != IDLE};
         default: apb.prdata = 32'd0;
      endcase
   end

   assign clk_fall = clk_sync[2] & ~clk_sync[1];
   assign frame    = {1'b1, parity, tx_byte};
   assign tmo_inc  = tmo_cnt + TW'(1);
   assign tmo_hit  = (tmo_inc == TW'(TIMEOUT_CYCLES));

   // Line synchronisers; reset to the idle-high line level so no false edge appears.
   always_ff @(posedge clock) begin
      if (reset) begin
         clk_sync  <= 3'b111;
         data_sync <= 2'b11;
      end else begin
         clk_sync  <= {clk_sync[1:0], ps2_clk};
         data_sync <= {data_sync[0], ps2_data};
      end
   end

   // State, counters and registered line drivers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         inh_cnt     <= '0;
         tmo_cnt     <= '0;
         bit_cnt     <= '0;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
      end else begin
         state       <= state_n;
         inh_cnt     <= inh_n;
         tmo_cnt     <= tmo_n;
         bit_cnt     <= bit_n;
         ps2_clk_oe  <= clk_oe_n;
         ps2_data_oe <= data_oe_n;
      end
   end

   // Next-state logic; line drive values are computed for the cycle being entered.
   always_comb begin
      state_n   = state;
      inh_n     = inh_cnt;
      tmo_n     = tmo_cnt;
      bit_n     = bit_cnt;
      clk_oe_n  = 1'b0;
      data_oe_n = ps2_data_oe;
      ack_evt   = 1'b0;
      tmo_evt   = 1'b0;
      case (state)
         IDLE: begin
            data_oe_n = 1'b0;
            if (wr_go) begin
               state_n   = INHIBIT;
               inh_n     = '0;
               clk_oe_n  = 1'b1;
               data_oe_n = (CLK_INHIBIT_CYCLES == 1);
            end
         end
         INHIBIT: begin
            clk_oe_n = 1'b1;
            if (inh_cnt == IW'(CLK_INHIBIT_CYCLES - 1)) begin
               state_n   = SEND;
               clk_oe_n  = 1'b0;
               data_oe_n = 1'b1;
               tmo_n     = '0;
               bit_n     = '0;
            end else begin
               inh_n     = inh_cnt + IW'(1);
               data_oe_n = (inh_n == IW'(CLK_INHIBIT_CYCLES - 1));
            end
         end
         SEND: begin
            tmo_n = tmo_inc;
            if (tmo_hit) begin
               state_n   = IDLE;
               data_oe_n = 1'b0;
               tmo_evt   = 1'b1;
            end else if (clk_fall) begin
               data_oe_n = ~frame[bit_cnt];
               bit_n     = bit_cnt + 4'd1;
               if (bit_cnt == 4'd9) state_n = ACK;
            end
         end
         ACK: begin
            tmo_n = tmo_inc;
            if (tmo_hit) begin
               state_n   = IDLE;
               data_oe_n = 1'b0;
               tmo_evt   = 1'b1;
            end else if (clk_fall) begin
               state_n   = IDLE;
               data_oe_n = 1'b0;
               ack_evt   = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Byte latch and sticky flags; later assignments win, so a flag set beats a STATUS-read clear.
   always_ff @(posedge clock) begin
      if (reset) begin
         tx_byte <= 8'd0;
         parity  <= 1'b0;
         done    <= 1'b0;
         ack_err <= 1'b0;
         timeout <= 1'b0;
      end else begin
         if (rd_status) begin
            done    <= 1'b0;
            ack_err <= 1'b0;
            timeout <= 1'b0;
         end
         if (ack_evt) begin
            done    <= 1'b1;
            ack_err <= data_sync[1];
         end
         if (tmo_evt) begin
            done    <= 1'b0;
            timeout <= 1'b1;
         end
         if (wr_go) begin
            tx_byte <= apb.pwdata[7:0];
            parity  <= ~^apb.pwdata[7:0];
            done    <= 1'b0;
            ack_err <= 1'b0;
            timeout <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_ps2_tx_apb.sv
// Directed bench for ps2_tx_apb: APB register access plus a PS/2 device model on open-drain lines.
module tb_ps2_tx_apb;
   logic clock = 1'b0;
   logic reset;
   logic ps2_clk, ps2_data, ps2_clk_oe, ps2_data_oe;
   logic dev_clk, dev_data;
   int   n_tests = 0;
   int   n_fail  = 0;

   ps2_tx_apb_if bus ();

   ps2_tx_apb #(.CLK_INHIBIT_CYCLES(8), .TIMEOUT_CYCLES(2000)) dut (
      .clock       (clock),
      .reset       (reset),
      .apb         (bus.slave),
      .ps2_clk     (ps2_clk),
      .ps2_data    (ps2_data),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe)
   );

   always #5 clock = ~clock;

   // Open-drain wired-AND of host and device drivers.
   assign ps2_clk  = dev_clk & ~ps2_clk_oe;
   assign ps2_data = dev_data & ~ps2_data_oe;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic apb_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic err);
      @(negedge clock);
      bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
      bus.paddr = addr; bus.pwdata = data; bus.pstrb = strb;
      @(negedge clock);
      bus.penable = 1'b1;
      #1 err = bus.pslverr;
      @(negedge clock);
      bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
   endtask

   task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
      @(negedge clock);
      bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = addr;
      @(negedge clock);
      bus.penable = 1'b1;
      #1 data = bus.prdata;
      @(negedge clock);
      bus.psel = 1'b0; bus.penable = 1'b0;
   endtask

   // Counts cycles of clock inhibit and where the start bit appears within it.
   task automatic meas_inhibit(output int n_low, output int n_start, output int start_pos);
      n_low = 0; n_start = 0; start_pos = 0;
      for (int i = 0; i < 100; i++) begin
         if (!ps2_clk_oe) break;
         n_low++;
         if (ps2_data_oe) begin n_start++; start_pos = n_low; end
         @(negedge clock);
      end
   endtask

   // Device: waits for the request-to-send, clocks nfall falling edges at a 20-cycle period,
   // captures the line on each rising edge, and optionally pulls data low for the ack edge.
   task automatic dev_xfer(input int nfall, input logic ack_low,
                           output logic start, output logic [9:0] cap, output logic ok);
      ok = 1'b0; start = 1'b1; cap = '0;
      for (int i = 0; i < 400 && !ok; i++) begin
         @(negedge clock);
         if (!ps2_clk_oe && ps2_data_oe) ok = 1'b1;
      end
      if (!ok) return;
      start = ps2_data;
      for (int n = 1; n <= nfall; n++) begin
         dev_clk = 1'b0;
         repeat (10) @(negedge clock);
         dev_clk = 1'b1;
         if (n <= 10) cap[n-1] = ps2_data;
         repeat (5) @(negedge clock);
         if (n == 10) dev_data = ~ack_low;
         repeat (5) @(negedge clock);
      end
      dev_data = 1'b1;
   endtask

   logic [31:0] rd;
   logic        err, err2, st, ok;
   logic [9:0]  cap;
   int          nl, ns, sp, cnt;

   initial begin
      reset = 1'b1; dev_clk = 1'b1; dev_data = 1'b1;
      bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.pprot = 3'd0;
      bus.paddr = '0; bus.pwdata = '0; bus.pstrb = '0;
      repeat (3) @(negedge clock);
      chk("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
      chk("rst_data_oe", {31'd0, ps2_data_oe}, 32'd0);
      reset = 1'b0;
      @(negedge clock);
      chk("idle_pready", {31'd0, bus.pready}, 32'd0);
      apb_read(32'h4, rd);  chk("rst_status", rd, 32'h0);
      apb_read(32'h0, rd);  chk("rst_txdata", rd, 32'h0);
      apb_read(32'h8, rd);  chk("unmapped_rd", rd, 32'h0);

      // Write without byte 0 strobe does nothing.
      apb_write(32'h0, 32'hAB, 4'b0010, err);
      chk("nostrb_err", {31'd0, err}, 32'd0);
      apb_read(32'h4, rd);  chk("nostrb_status", rd, 32'h0);
      apb_read(32'h0, rd);  chk("nostrb_txdata", rd, 32'h0);

      // 0xED, device acks: parity = ~^0xED = 1.
      apb_write(32'h0, 32'hED, 4'b0001, err);
      chk("ed_err", {31'd0, err}, 32'd0);
      meas_inhibit(nl, ns, sp);
      chk("ed_inhibit_len", nl, 8);
      chk("ed_start_cnt", ns, 1);
      chk("ed_start_pos", sp, 8);
      dev_xfer(11, 1'b1, st, cap, ok);
      chk("ed_rts", {31'd0, ok}, 32'd1);
      chk("ed_start", {31'd0, st}, 32'd0);
      chk("ed_frame", {22'd0, cap}, 32'h3ED);
      chk("ed_release", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
      apb_read(32'h4, rd);  chk("ed_status", rd, 32'h2);
      apb_read(32'h4, rd);  chk("ed_status_clr", rd, 32'h0);
      apb_read(32'h0, rd);  chk("ed_txdata", rd, 32'hED);

      // 0x00, device leaves data high at ack.
      apb_write(32'h0, 32'h00, 4'b0001, err);
      meas_inhibit(nl, ns, sp);
      chk("00_inhibit_len", nl, 8);
      dev_xfer(11, 1'b0, st, cap, ok);
      chk("00_start", {31'd0, st}, 32'd0);
      chk("00_frame", {22'd0, cap}, 32'h300);
      apb_read(32'h4, rd);  chk("00_status", rd, 32'h6);
      apb_read(32'h4, rd);  chk("00_status_clr", rd, 32'h0);

      // 0x55 with a rejected second write mid-frame.
      apb_write(32'h0, 32'h55, 4'b0001, err);
      meas_inhibit(nl, ns, sp);
      fork
         dev_xfer(11, 1'b1, st, cap, ok);
         begin
            repeat (40) @(negedge clock);
            apb_write(32'h0, 32'h99, 4'b0001, err);
            apb_write(32'hC, 32'h99, 4'b0001, err2);
         end
      join
      chk("55_busy_err", {31'd0, err}, 32'd1);
      chk("55_unmapped_err", {31'd0, err2}, 32'd0);
      chk("55_frame", {22'd0, cap}, 32'h355);
      apb_read(32'h0, rd);  chk("55_txdata", rd, 32'h55);
      apb_read(32'h4, rd);  chk("55_status", rd, 32'h2);

      // 0xF4, device silent: timeout after 2000 cycles in SEND.
      apb_write(32'h0, 32'hF4, 4'b0001, err);
      meas_inhibit(nl, ns, sp);
      cnt = 0;
      for (int i = 0; i < 3000; i++) begin
         if (!(ps2_data_oe && !ps2_clk_oe)) break;
         cnt++;
         @(negedge clock);
      end
      chk("f4_send_cycles", cnt, 2000);
      chk("f4_release", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
      apb_read(32'h4, rd);  chk("f4_status", rd, 32'h8);

      // 0xAA interrupted by reset after edge 4, then a clean 0x12 frame.
      apb_write(32'h0, 32'hAA, 4'b0001, err);
      meas_inhibit(nl, ns, sp);
      dev_xfer(4, 1'b0, st, cap, ok);
      chk("aa_partial", {28'd0, cap[3:0]}, 32'hA);
      reset = 1'b1;
      @(negedge clock);
      chk("aa_rst_release", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
      reset = 1'b0;
      apb_read(32'h4, rd);  chk("aa_rst_status", rd, 32'h0);
      apb_read(32'h0, rd);  chk("aa_rst_txdata", rd, 32'h0);
      apb_write(32'h0, 32'h12, 4'b0001, err);
      chk("12_err", {31'd0, err}, 32'd0);
      meas_inhibit(nl, ns, sp);
      chk("12_inhibit_len", nl, 8);
      dev_xfer(11, 1'b1, st, cap, ok);
      chk("12_start", {31'd0, st}, 32'd0);
      chk("12_frame", {22'd0, cap}, 32'h312);
      apb_read(32'h4, rd);  chk("12_status", rd, 32'h2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
